// File: rtl/rda_seq_adder.sv
// rda_seq_adder: W-bit adder (W = 16*NCHUNK) built from one 16-bit
// recursive-doubling adder that is reused once per chunk, LSB chunk first.
// The carry out of each chunk feeds the carry in of the next chunk.

// double: 16-bit recursive-doubling (Kogge-Stone) adder.
// The carry-in is folded in as generate bit 0, so after the prefix pass
// g[i] is the carry into operand bit i and g[16] is the carry-out.
module double (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum
);

  // Log-depth prefix pass. Descending i keeps reads of g/p[i-d] at the
  // previous level's values.
  always_comb begin
    logic [16:0] g;
    logic [16:0] p;
    g = {a & b, cin};
    p = {a ^ b, 1'b0};
    for (int d = 1; d < 17; d = d * 2) begin
      for (int i = 16; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    sum = {g[16], (a ^ b) ^ g[15:0]};
  end

endmodule

module rda_seq_adder #(
  parameter int NCHUNK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16*NCHUNK-1:0] a,
  input  logic [16*NCHUNK-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*NCHUNK:0]   sum
);

  localparam int W  = 16 * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          c_q, c_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W:0]    sum_q, sum_d;
  logic          out_valid_q, out_valid_d;

  logic [15:0]   add_a, add_b;
  logic [16:0]   add_sum;

  // The one shared adder always sees the chunk selected by idx.
  assign add_a = a_q[16*idx_q +: 16];
  assign add_b = b_q[16*idx_q +: 16];

  double u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (c_q),
    .sum (add_sum)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

  // Next-state: capture operands in IDLE, one chunk per cycle in RUN,
  // hold the result in DONE until downstream takes it.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[16*idx_q +: 16] = add_sum[15:0];
        c_d                   = add_sum[16];
        if (idx_q == LAST) begin
          sum_d[W]    = add_sum[16];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/rda_seq_adder.md
Name: rda_seq_adder

Overview:
Multi-cycle wide adder built around one instance of the team's existing 16-bit recursive-doubling adder `double` (ports a[15:0], b[15:0], cin, sum[16:0]). It accepts wide operands over a valid/ready handshake and feeds the adder one 16-bit chunk per cycle, LSB chunk first. It consumes each 17-bit chunk sum, chaining sum[16] into the next chunk's cin. It presents the full result downstream with a valid/ready handshake.

Parameters:
NCHUNK, 2, number of 16-bit chunks; operand width W = 16*NCHUNK; legal range 1..8

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and cin valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in to chunk 0
out_valid  output  1  sum valid
out_ready  input  1  downstream accepts sum
sum  output  W+1  result; sum[W] is final carry-out

Behaviour:
- Clocking: single clock `clk`, rising edge. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - sum = 0
  - internal operand, carry and index registers = 0
- Reset mid-operation aborts the operation with no output.
- in_ready is decoded from state: 1 exactly when state == IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with in_valid && in_ready: latch a -> a_q, b -> b_q, cin -> c_q; idx <= 0; state <= RUN.
  - Otherwise hold.
- RUN:
  - Adder inputs: a = a_q[16*idx +: 16], b = b_q[16*idx +: 16], cin = c_q.
  - Each edge: sum[16*idx +: 16] <= adder.sum[15:0]; c_q <= adder.sum[16].
  - If idx == NCHUNK-1: sum[W] <= adder.sum[16]; out_valid <= 1; state <= DONE.
  - Else idx <= idx + 1.
- DONE:
  - out_valid = 1; sum is held stable.
  - On an edge with out_ready = 1: out_valid <= 0; state <= IDLE.
  - While out_ready = 0, hold indefinitely (no timeout).
- Latency: if the operand handshake completes at edge E0, out_valid rises after edge E0+NCHUNK.
- Throughput: one operation per NCHUNK+2 cycles minimum. There is no overlap; in_ready stays low in RUN and DONE.
- Inputs a, b, cin and in_valid are ignored outside IDLE. Changing them mid-operation has no effect on the result.
- out_ready is ignored outside DONE.
- sum is only guaranteed meaningful while out_valid = 1. Partially written chunks are visible during RUN and must not be sampled.
- Arithmetic: result = a + b + cin, modulo 2^(W+1). This is exact with no overflow loss, since sum[W] holds the carry-out.
- NCHUNK = 1: a single RUN cycle; the block then behaves as a registered `double`.
- idx register width is $clog2(NCHUNK) with a minimum of 1 bit.

Test Plan:
- NCHUNK=2 carry ripple across the chunk boundary: a=32'h0000_FFFF, b=32'h0000_0001, cin=0 -> sum=33'h0_0001_0000. out_valid rises 2 cycles after acceptance; in_ready is low throughout RUN and DONE.
- Full carry-out: a=32'hFFFF_FFFF, b=0, cin=1 -> sum=33'h1_0000_0000. Also a=b=0, cin=1 -> sum=1.
- Backpressure: result 600+807=1407 with out_ready held low 5 cycles -> sum stays 1407 and out_valid stays 1. in_ready stays 0 while in_valid is driven with new operands (a=1025). After out_ready=1, returns to IDLE; the next accepted op 1025+807+cin=1 yields 1833.
- Operand change mid-op: accept a=65535, b=56, cin=0, then drive a=0, b=0 during RUN -> sum=65591, unaffected.
- Reset mid-RUN: assert rst_n=0 asynchronously in RUN -> out_valid=0 and sum=0 immediately. in_ready=1 after release; no stale result ever appears.
- NCHUNK=1 build: 100 random {a,b,cin} vectors compared against a+b+cin; latency is 1 cycle; back-to-back handshakes with out_ready tied high.
